prog_mem_server: RTL and testbench

PROG_MEM_SERVER -- requirements
Module: prog_mem_server

---
 rtl/prog_mem_server.sv | 210 +++++++++++++++++++++
 tb/tb_prog_mem_server.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_server.sv
// prog_mem_server: 256 x 16 program store with a wait-stated, single-outstanding CPU fetch port.
// Words are loaded through ld_*; a fetch of an opcode 4'hF word (HALT) parks the server until resume.
// Build option: define PROG_MEM_PARITY_EN to store an even-parity bit per word and add parity_err.
module prog_mem_server #(
    parameter int unsigned WAIT_CYCLES   = 1,
    parameter logic [15:0] MEM_INIT_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        pon_rst_n_i,
    input  logic        ld_we,
    input  logic [7:0]  ld_addr,
    input  logic [15:0] ld_data,
    input  logic        fetch_req,
    input  logic [12:0] fetch_addr,
    input  logic        resume,
    output logic        fetch_ready,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic        halted,
    output logic        addr_err,
    output logic [15:0] fetch_count
`ifdef PROG_MEM_PARITY_EN
    ,
    output logic        parity_err
`endif
);

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned PCW   = 13;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 256;
`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned MW    = DW + 1;
`else
    localparam int unsigned MW    = DW;
`endif
    localparam logic [DW-1:0] NOP_WORD  = 16'h0000;
    localparam logic [DW-1:0] HALT_WORD = 16'hF000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_RESP   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [PCW-1:0]   addr_q, addr_d;
    logic             fetch_ready_q, fetch_ready_d;
    logic [DW-1:0]    instr_q, instr_d;
    logic             instr_valid_q, instr_valid_d;
    logic             halted_q, halted_d;
    logic             addr_err_q, addr_err_d;
    logic [DW-1:0]    fetch_count_q, fetch_count_d;

    // Storage and the registered read port (not reset: contents survive reset)
    logic [MW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] loaded_q;
    logic [DW-1:0]    rd_word_q;
    logic             rd_oor_q;

    logic             rd_en_c;
    logic [PCW-1:0]   rd_addr_c;
    logic             rd_oor_c;
    logic [MW-1:0]    rd_raw_c;
    logic [DW-1:0]    rd_word_c;
    logic [MW-1:0]    wr_word_c;

`ifdef PROG_MEM_PARITY_EN
    logic             parity_err_q, parity_err_d;
    logic             rd_par_q;
    logic             rd_par_c;
`endif

    // Read-side data: range check, unloaded fill, optional parity check
    always_comb begin
        rd_addr_c = (state_q == S_IDLE) ? fetch_addr : addr_q;
        rd_oor_c  = |rd_addr_c[PCW-1:AW];
        rd_raw_c  = mem_q[rd_addr_c[AW-1:0]];
        rd_word_c = loaded_q[rd_addr_c[AW-1:0]] ? rd_raw_c[DW-1:0] : MEM_INIT_WORD;
`ifdef PROG_MEM_PARITY_EN
        wr_word_c = {^ld_data, ld_data};
        rd_par_c  = !rd_oor_c && loaded_q[rd_addr_c[AW-1:0]] && (^rd_raw_c);
        if (rd_par_c) begin
            rd_word_c = HALT_WORD;
        end
`else
        wr_word_c = ld_data;
`endif
        if (rd_oor_c) begin
            rd_word_c = NOP_WORD;
        end
    end

    // Load writes and fetch reads share one edge, so a colliding read sees the old word
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_q[ld_addr]    <= wr_word_c;
            loaded_q[ld_addr] <= 1'b1;
        end
        if (rd_en_c) begin
            rd_word_q <= rd_word_c;
            rd_oor_q  <= rd_oor_c;
`ifdef PROG_MEM_PARITY_EN
            rd_par_q  <= rd_par_c;
`endif
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        addr_d        = addr_q;
        rd_en_c       = 1'b0;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        addr_err_d    = addr_err_q;
        fetch_count_d = fetch_count_q;
`ifdef PROG_MEM_PARITY_EN
        parity_err_d  = parity_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    addr_d = fetch_addr;
                    if (WAIT_CYCLES == 0) begin
                        rd_en_c = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        wait_cnt_d = CW'(WAIT_CYCLES - 1);
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    rd_en_c = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = CW'(wait_cnt_q - CW'(1));
                end
            end
            S_RESP: begin
                instr_valid_d = 1'b1;
                instr_d       = rd_word_q;
                addr_err_d    = addr_err_q | rd_oor_q;
`ifdef PROG_MEM_PARITY_EN
                parity_err_d  = parity_err_q | rd_par_q;
`endif
                if (fetch_count_q != 16'hFFFF) begin
                    fetch_count_d = DW'(fetch_count_q + DW'(1));
                end
                state_d = (rd_word_q[15:12] == 4'hF) ? S_HALTED : S_IDLE;
            end
            S_HALTED: begin
                if (resume) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        fetch_ready_d = (state_d == S_IDLE);
        halted_d      = (state_d == S_HALTED);
    end

    // State and output registers
    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            addr_q        <= '0;
            fetch_ready_q <= 1'b1;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            addr_err_q    <= 1'b0;
            fetch_count_q <= '0;
`ifdef PROG_MEM_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            addr_q        <= addr_d;
            fetch_ready_q <= fetch_ready_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            addr_err_q    <= addr_err_d;
            fetch_count_q <= fetch_count_d;
`ifdef PROG_MEM_PARITY_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign fetch_ready = fetch_ready_q;
    assign instruction = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign addr_err    = addr_err_q;
    assign fetch_count = fetch_count_q;
`ifdef PROG_MEM_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_prog_mem_server.sv
// Bench for prog_mem_server: one instance with one wait cycle, one with three.
// Both share load, reset and resume; each has its own fetch request and response scoreboard.
module tb_prog_mem_server;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        req1, req3;
    logic [12:0] faddr;
    logic        resume;

    logic        rdy1, val1, halt1, aerr1;
    logic [15:0] instr1, cnt1;
    logic        rdy3, val3, halt3, aerr3;
    logic [15:0] instr3, cnt3;
`ifdef PROG_MEM_PARITY_EN
    logic        perr1, perr3;
`endif

    always #5 clk = ~clk;

    prog_mem_server #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .pon_rst_n_i(rst_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_req(req1), .fetch_addr(faddr), .resume(resume),
        .fetch_ready(rdy1), .instruction(instr1), .instr_valid(val1), .halted(halt1),
        .addr_err(aerr1), .fetch_count(cnt1)
`ifdef PROG_MEM_PARITY_EN
        , .parity_err(perr1)
`endif
    );

    prog_mem_server #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .pon_rst_n_i(rst_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_req(req3), .fetch_addr(faddr), .resume(resume),
        .fetch_ready(rdy3), .instruction(instr3), .instr_valid(val3), .halted(halt3),
        .addr_err(aerr3), .fetch_count(cnt3)
`ifdef PROG_MEM_PARITY_EN
        , .parity_err(perr3)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt [2];
    logic [15:0] q1 [$];
    logic [15:0] q3 [$];
    logic [15:0] mon_e1, mon_e3;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_rdy(input int sel);   return sel != 0 ? rdy3 : rdy1;     endfunction
    function automatic logic get_val(input int sel);   return sel != 0 ? val3 : val1;     endfunction
    function automatic logic get_halt(input int sel);  return sel != 0 ? halt3 : halt1;   endfunction
    function automatic logic [15:0] get_instr(input int sel); return sel != 0 ? instr3 : instr1; endfunction
    function automatic logic [15:0] get_cnt(input int sel);   return sel != 0 ? cnt3 : cnt1;     endfunction

    // Scoreboards: every delivered word must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (val1) begin
            if (q1.size() == 0) check("unexpected_valid1", 32'd1, 32'd0);
            else begin
                mon_e1 = q1.pop_front();
                check("sb_instr1", {16'd0, instr1}, {16'd0, mon_e1});
            end
        end
        if (val3) begin
            if (q3.size() == 0) check("unexpected_valid3", 32'd1, 32'd0);
            else begin
                mon_e3 = q3.pop_front();
                check("sb_instr3", {16'd0, instr3}, {16'd0, mon_e3});
            end
        end
    end

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // One fetch on instance sel; optionally collide a load write with the read edge
    task automatic fetch(input int sel, input logic [12:0] a, input logic [15:0] e,
                         input bit wr, input logic [15:0] wd);
        int  lat;
        bit  got;
        logic hlt;
        @(negedge clk);
        check("ready_before", {31'd0, get_rdy(sel)}, 32'd1);
        faddr = a;
        if (sel == 0) begin req1 = 1'b1; q1.push_back(e); end
        else begin req3 = 1'b1; q3.push_back(e); end
        @(posedge clk);
        #1;
        req1 = 1'b0; req3 = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (wr && lat == 1) begin ld_we = 1'b1; ld_addr = a[7:0]; ld_data = wd; end
            if (lat == 2) ld_we = 1'b0;
            if (get_val(sel)) got = 1'b1;
        end
        if (!got) check("fetch_timeout", 32'd0, 32'd1);
        else begin
            check("latency", lat, (sel != 0 ? 3 : 1) + 2);
            hlt = (e[15:12] == 4'hF);
            exp_cnt[sel]++;
            check("count", {16'd0, get_cnt(sel)}, exp_cnt[sel]);
            check("halted_at_resp", {31'd0, get_halt(sel)}, {31'd0, hlt});
            check("ready_at_resp", {31'd0, get_rdy(sel)}, {31'd0, !hlt});
            @(negedge clk);
            check("valid_pulse", {31'd0, get_val(sel)}, 32'd0);
            check("instr_hold", {16'd0, get_instr(sel)}, {16'd0, e});
        end
    endtask

    task automatic check_reset_vals(input int sel);
        check("rst_ready", {31'd0, get_rdy(sel)}, 32'd1);
        check("rst_instr", {16'd0, get_instr(sel)}, 32'd0);
        check("rst_valid", {31'd0, get_val(sel)}, 32'd0);
        check("rst_halted", {31'd0, get_halt(sel)}, 32'd0);
        check("rst_count", {16'd0, get_cnt(sel)}, 32'd0);
    endtask

    task automatic pulse_resume();
        @(negedge clk);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        req1 = 1'b0; req3 = 1'b0; faddr = '0; resume = 1'b0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        tbl[0] = '{a: 8'h05, d: 16'h1250};
        tbl[1] = '{a: 8'h00, d: 16'h0A5A};
        tbl[2] = '{a: 8'h09, d: 16'h4321};
        tbl[3] = '{a: 8'hFF, d: 16'hE00F};
        tbl[4] = '{a: 8'h80, d: 16'h7FFE};
        tbl[5] = '{a: 8'h3C, d: 16'h0001};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        check("rst_addr_err1", {31'd0, aerr1}, 32'd0);

        // Table: load every word, fetch all on the 1-wait server and some on the 3-wait one
        foreach (tbl[i]) load(tbl[i].a, tbl[i].d);
        foreach (tbl[i]) fetch(0, {5'd0, tbl[i].a}, tbl[i].d, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) fetch(1, {5'd0, tbl[i].a}, tbl[i].d, 1'b0, 16'h0);

        // Load colliding with the read edge returns the old word, then the new one
        fetch(0, 13'h0005, 16'h1250, 1'b1, 16'hABCD);
        fetch(0, 13'h0005, 16'hABCD, 1'b0, 16'h0);
        load(8'h05, 16'h1250);

        // Resume while idle does nothing
        pulse_resume();
        check("resume_idle_ready", {31'd0, rdy1}, 32'd1);
        check("resume_idle_halt", {31'd0, halt1}, 32'd0);

        // HALT: park, ignore requests, release on resume
        load(8'h03, 16'hF000);
        fetch(0, 13'h0003, 16'hF000, 1'b0, 16'h0);
        @(negedge clk);
        faddr = 13'h0005; req1 = 1'b1;
        repeat (5) @(negedge clk);
        req1 = 1'b0;
        check("halt_holds", {31'd0, halt1}, 32'd1);
        check("halt_not_ready", {31'd0, rdy1}, 32'd0);
        check("halt_count", {16'd0, cnt1}, exp_cnt[0]);
        @(negedge clk);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("resume_ready", {31'd0, rdy1}, 32'd1);
        check("resume_halt", {31'd0, halt1}, 32'd0);
        fetch(0, 13'h0009, 16'h4321, 1'b0, 16'h0);

        // Reset while the 3-wait server is in WAIT: request abandoned, memory kept
        @(negedge clk);
        faddr = 13'h0009; req3 = 1'b1;
        @(posedge clk);
        #1;
        req3 = 1'b0;
        @(negedge clk);
        check("busy_in_wait", {31'd0, rdy3}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_vals(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_pulse_count", {16'd0, cnt3}, 32'd0);
        check("no_pulse_instr", {16'd0, instr3}, 32'd0);
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        fetch(1, 13'h0009, 16'h4321, 1'b0, 16'h0);
        fetch(0, 13'h00FF, 16'hE00F, 1'b0, 16'h0);

        // Out-of-range: NOP and sticky addr_err until reset
        fetch(0, 13'h0100, 16'h0000, 1'b0, 16'h0);
        check("addr_err_set", {31'd0, aerr1}, 32'd1);
        fetch(0, 13'h0005, 16'h1250, 1'b0, 16'h0);
        fetch(0, 13'h1F80, 16'h0000, 1'b0, 16'h0);
        fetch(0, 13'h0080, 16'h7FFE, 1'b0, 16'h0);
        check("addr_err_sticky", {31'd0, aerr1}, 32'd1);
        check("addr_err_other", {31'd0, aerr3}, 32'd0);

`ifdef PROG_MEM_PARITY_EN
        // Corrupted parity reads back as HALT
        load(8'h07, 16'h2222);
        @(negedge clk);
        u_dut1.mem_q[7][16] = ~u_dut1.mem_q[7][16];
        fetch(0, 13'h0007, 16'hF000, 1'b0, 16'h0);
        check("parity_err", {31'd0, perr1}, 32'd1);
        pulse_resume();
`endif

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("addr_err_cleared", {31'd0, aerr1}, 32'd0);
        check_reset_vals(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
